servo_pwm_capture: RTL and testbench



---
 rtl/servo_pwm_capture.sv | 125 ++++++++++++
 tb/tb_servo_pwm_capture.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_capture.sv
// Servo/RC PWM receiver: synchronizes and deglitches the pad input, then
// measures high time and rising-to-rising period in clk cycles.
module servo_pwm_capture #(
  parameter int CNT_W      = 24,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 1300000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_input,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] pulse,
  output logic             valid,
  output logic             timed_out,
  output logic             level
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic             sync1_q, sync2_q;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             rise, fall, timeout_hit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] period_q, pulse_q;
  logic             valid_q, timed_out_q;
  state_t           state_q;

  // Level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    fcnt_d  = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      fcnt_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync1_q     <= pwm_input;
      sync2_q     <= sync1_q;
      fcnt_q      <= fcnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign rise        = level_q & ~level_dly_q;
  assign fall        = ~level_q & level_dly_q;
  assign timeout_hit = (cnt_q >= CNT_W'(TIMEOUT));

  always_comb begin
    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Edges take priority over the timeout check in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      high_cnt_q  <= '0;
      period_q    <= '0;
      pulse_q     <= '0;
      valid_q     <= 1'b0;
      timed_out_q <= 1'b0;
      state_q     <= IDLE;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) state_q <= HIGH;
        end
        HIGH: begin
          if (fall) begin
            high_cnt_q <= cnt_q;
            state_q    <= LOW;
          end else if (timeout_hit) begin
            timed_out_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        LOW: begin
          if (rise) begin
            period_q    <= cnt_q;
            pulse_q     <= high_cnt_q;
            valid_q     <= 1'b1;
            timed_out_q <= 1'b0;
            state_q     <= HIGH;
          end else if (timeout_hit) begin
            timed_out_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign period    = period_q;
  assign pulse     = pulse_q;
  assign valid     = valid_q;
  assign timed_out = timed_out_q;
  assign level     = level_q;

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Directed + randomized bench for servo_pwm_capture with scaled-down timing;
// a segment-level reference model predicts every published measurement.
module tb_servo_pwm_capture;

  localparam int CW = 16;
  localparam int FL = 4;
  localparam int TO = 3000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pwm_input = 1'b0;
  logic [CW-1:0] period, pulse;
  logic          valid, timed_out, level;

  servo_pwm_capture #(.CNT_W(CW), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .pwm_input(pwm_input),
    .period(period), .pulse(pulse), .valid(valid),
    .timed_out(timed_out), .level(level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Observed events
  logic [31:0] got_q[$];
  int got_to = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  int to_cyc = 0;
  int dbl_valid = 0;
  int to_at_valid = 0;
  logic prev_valid = 1'b0;
  logic prev_to = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (valid === 1'b1) begin
      got_q.push_back({period, pulse});
      last_valid_cyc = cyc;
      if (prev_valid === 1'b1) dbl_valid = dbl_valid + 1;
      if (timed_out !== 1'b0) to_at_valid = to_at_valid + 1;
    end
    if (timed_out === 1'b1 && prev_to !== 1'b1) begin
      got_to = got_to + 1;
      to_cyc = cyc;
    end
    prev_valid = valid;
    prev_to = timed_out;
  end

  // Reference model: works on whole input segments, not cycles.
  logic [31:0] exp_q[$];
  int exp_to = 0;
  int m_st = 0;      // 0 idle, 1 high seen, 2 fall seen
  int m_since = 0;
  int m_hi = 0;
  int m_last_p = 0;
  int m_last_h = 0;
  logic cur_lvl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_seg(input logic lvl, input int dur);
    if (lvl && !cur_lvl) begin
      if (m_st == 2) begin
        exp_q.push_back({CW'(m_since), CW'(m_hi)});
        m_last_p = m_since;
        m_last_h = m_hi;
      end
      m_st = 1;
      m_since = 0;
    end else if (!lvl && cur_lvl) begin
      if (m_st == 1) begin
        m_hi = m_since;
        m_st = 2;
      end
    end
    if (m_st != 0 && m_since + dur > TO) begin
      exp_to++;
      m_st = 0;
    end
    m_since += dur;
    cur_lvl = lvl;
  endtask

  task automatic seg(input logic lvl, input int dur);
    model_seg(lvl, dur);
    pwm_input = lvl;
    repeat (dur) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag);
    seg(cur_lvl, 20);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_period"}, got_q[i][31:16], exp_q[i][31:16]);
      chk({tag, "_pulse"}, got_q[i][15:0], exp_q[i][15:0]);
      $display("[TB] %s meas %0d: period=%0d pulse=%0d", tag, i, got_q[i][31:16], got_q[i][15:0]);
    end
    chk({tag, "_timeouts"}, got_to, exp_to);
    chk({tag, "_hold_period"}, period, m_last_p);
    chk({tag, "_hold_pulse"}, pulse, m_last_h);
    got_q.delete();
    exp_q.delete();
    got_to = 0;
    exp_to = 0;
  endtask

  task automatic do_reset(input string tag);
    pwm_input = 1'b0;
    cur_lvl = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk({tag, "_rst_period"}, period, 0);
    chk({tag, "_rst_pulse"}, pulse, 0);
    chk({tag, "_rst_valid"}, valid, 0);
    chk({tag, "_rst_timed_out"}, timed_out, 0);
    chk({tag, "_rst_level"}, level, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_st = 0; m_since = 0; m_hi = 0; m_last_p = 0; m_last_h = 0;
    got_q.delete(); exp_q.delete();
    got_to = 0; exp_to = 0;
  endtask

  initial begin
    logic seen;
    @(posedge clk);
    #1;
    do_reset("init");

    // Steady PWM, then loss of signal and restart
    seg(0, 100);
    for (int i = 0; i < 4; i++) begin
      seg(1, 150);
      seg(0, 1850);
    end
    seg(1, 150);
    compare("steady");
    seg(0, TO + 100);
    chk("loss_timing", to_cyc - last_valid_cyc, TO);
    compare("loss");
    seg(1, 150);
    chk("restart_1st_to", timed_out, 1);
    seg(0, 1850);
    seg(1, 150);
    chk("restart_2nd_to", timed_out, 0);
    seg(0, 1850);
    compare("restart");

    // Width change with fixed period
    do_reset("width");
    seg(0, 100);
    for (int i = 0; i < 3; i++) begin seg(1, 100); seg(0, 1900); end
    for (int i = 0; i < 3; i++) begin seg(1, 200); seg(0, 1800); end
    seg(1, 200);
    compare("width");

    // Glitch rejection: 3-cycle spike ignored, 4-cycle spike accepted
    do_reset("glitch");
    seen = 1'b0;
    pwm_input = 1'b1;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; seen |= level; end
    pwm_input = 1'b0;
    for (int k = 0; k < 20; k++) begin @(posedge clk); #1; seen |= level; end
    chk("glitch3_level", seen, 0);
    model_seg(1, 4);
    pwm_input = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) pwm_input = 1'b0;
      if (k == 5) chk("glitch4_level_early", level, 0);
      if (k == 6) chk("glitch4_level_rise", level, 1);
    end
    model_seg(0, 2);
    seg(0, 200);
    seg(1, 100);
    seg(0, 100);
    compare("glitch");

    // Stuck high after one normal cycle
    do_reset("stuck");
    seg(0, 50);
    seg(1, 100);
    seg(0, 1000);
    seg(1, 4000);
    compare("stuck_hi");
    chk("stuck_to_flag", timed_out, 1);
    seg(0, 500);
    seg(1, 300);
    seg(0, 600);
    seg(1, 300);
    seg(0, TO + 100);
    compare("stuck_recover");

    // Reset in the middle of a high phase
    do_reset("midrst");
    seg(0, 100);
    for (int i = 0; i < 2; i++) begin seg(1, 150); seg(0, 1850); end
    seg(1, 150);
    compare("pre_rst");
    seg(0, 1850);
    seg(1, 1000);
    do_reset("midhigh");
    seg(0, 100);
    seg(1, 300); seg(0, 900);
    seg(1, 300); seg(0, TO + 100);
    compare("post_rst");

    // Randomized widths, occasionally long enough to time out
    do_reset("rand");
    seg(0, 50);
    for (int i = 0; i < 8; i++) begin
      seg(1, int'($urandom_range(1200, 10)));
      seg(0, int'($urandom_range(2200, 10)));
    end
    seg(1, int'($urandom_range(1200, 10)));
    seg(0, TO + 100);
    compare("rand");

    chk("valid_single_cycle", dbl_valid, 0);
    chk("timed_out_clear_at_valid", to_at_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
